pwm_multi_channel: RTL and testbench

//   Parametrised multi-channel PWM generator; successor to the single-channel 8-bit PWM.

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_prescaler.sv | 26 ++
 rtl/pwm_multi_channel.sv | 129 ++++++++++++
 tb/tb_pwm_multi_channel.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM generator.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTRE = 1'b1;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_CHANNELS   = 4;
    localparam int DEF_PRESCALE_W = 8;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: emits a one-cycle tick every (prescale+1) clk cycles while enabled.
module pwm_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pcnt;

    assign tick = enable && (pcnt == prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (!enable || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM with shared edge/centre-aligned timebase and double-buffered
// period/mode/duty that swap into the active set on period boundaries.
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [PRESCALE_W-1:0]     prescale,
    input  logic [WIDTH-1:0]          period,
    input  logic                      mode,
    input  logic [CHANNELS*WIDTH-1:0] duty_flat,
    input  logic [CHANNELS-1:0]       polarity,
    input  logic                      load,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_tick
);

    logic                             tick;
    logic                             boundary;
    logic                             tick_q;
    logic [WIDTH-1:0]                 cnt;
    dir_e                             dir;
    logic [WIDTH-1:0]                 per_sh, per_act;
    logic                             mode_sh, mode_act;
    logic [CHANNELS-1:0][WIDTH-1:0]   duty_in, duty_sh, duty_act;
    logic [CHANNELS-1:0]              raw;

    assign duty_in = duty_flat;

    pwm_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .prescale (prescale),
        .tick     (tick)
    );

    // Centre mode with P=1 reaches cnt=1 still heading up, so it closes the period there too.
    always_comb begin
        boundary = 1'b0;
        if (tick) begin
            if (mode_act == MODE_EDGE) begin
                boundary = (cnt >= per_act);
            end else if (per_act == '0) begin
                boundary = 1'b1;
            end else begin
                boundary = (cnt == WIDTH'(1)) &&
                           ((dir == DIR_DOWN) || (per_act == WIDTH'(1)));
            end
        end
    end

    // Every boundary lands on cnt=0 heading up, whatever the mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            dir <= DIR_UP;
        end else if (!enable || boundary) begin
            cnt <= '0;
            dir <= DIR_UP;
        end else if (tick) begin
            if (mode_act == MODE_EDGE) begin
                cnt <= cnt + WIDTH'(1);
            end else if (dir == DIR_UP) begin
                if (cnt >= per_act) begin
                    cnt <= cnt - WIDTH'(1);
                    dir <= DIR_DOWN;
                end else begin
                    cnt <= cnt + WIDTH'(1);
                end
            end else if (cnt <= WIDTH'(1)) begin
                cnt <= '0;
                dir <= DIR_UP;
            end else begin
                cnt <= cnt - WIDTH'(1);
            end
        end
    end

    // A load on the swap cycle bypasses the shadow; when stopped it goes straight to active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_sh   <= '0;
            mode_sh  <= MODE_EDGE;
            duty_sh  <= '0;
            per_act  <= '0;
            mode_act <= MODE_EDGE;
            duty_act <= '0;
        end else begin
            if (load) begin
                per_sh  <= period;
                mode_sh <= mode;
                duty_sh <= duty_in;
            end
            if (load && (!enable || boundary)) begin
                per_act  <= period;
                mode_act <= mode;
                duty_act <= duty_in;
            end else if (boundary) begin
                per_act  <= per_sh;
                mode_act <= mode_sh;
                duty_act <= duty_sh;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_cmp
        assign raw[i] = (cnt < duty_act[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= '0;
            tick_q  <= 1'b0;
        end else begin
            pwm_out <= enable ? (raw ^ polarity) : polarity;
            tick_q  <= boundary;
        end
    end

    // Gate so a boundary registered just before disable never shows while stopped.
    assign period_tick = tick_q & enable;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Randomised scoreboard bench for pwm_multi_channel against a position-in-period reference model.
module tb_pwm_multi_channel;
    import pwm_pkg::*;

    localparam int W  = 8;
    localparam int C  = 4;
    localparam int PW = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic [PW-1:0]  prescale = '0;
    logic [W-1:0]   period = '0;
    logic           mode = MODE_EDGE;
    logic [C*W-1:0] duty_flat = '0;
    logic [C-1:0]   polarity = '0;
    logic           load = 1'b0;
    logic [C-1:0]   pwm_out;
    logic           period_tick;

    pwm_multi_channel #(.WIDTH(W), .CHANNELS(C), .PRESCALE_W(PW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .prescale    (prescale),
        .period      (period),
        .mode        (mode),
        .duty_flat   (duty_flat),
        .polarity    (polarity),
        .load        (load),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [C-1:0] out;
        logic         tick;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model: a prescale count, the tick position within the period, and the two config sets.
    int   m_pc, m_pos;
    int   a_per, s_per;
    bit   a_mode, s_mode;
    int   a_duty[C], s_duty[C];

    function automatic int len_of();
        if (a_mode == MODE_EDGE) return a_per + 1;
        return (a_per == 0) ? 1 : 2 * a_per;
    endfunction

    function automatic int cnt_at(input int pos);
        if (a_mode == MODE_EDGE || pos <= a_per) return pos;
        return 2 * a_per - pos;
    endfunction

    function automatic void reset_model();
        m_pc = 0; m_pos = 0;
        a_per = 0; s_per = 0; a_mode = 0; s_mode = 0;
        for (int i = 0; i < C; i++) begin a_duty[i] = 0; s_duty[i] = 0; end
    endfunction

    function automatic void grab(input bit to_active);
        s_per = period; s_mode = mode;
        for (int i = 0; i < C; i++) s_duty[i] = duty_flat[i*W +: W];
        if (to_active) begin
            a_per = s_per; a_mode = s_mode;
            for (int i = 0; i < C; i++) a_duty[i] = s_duty[i];
        end
    endfunction

    // Predict what the DUT shows after the coming posedge, then advance one clk.
    task automatic step();
        exp_t e;
        bit   tk, bnd;
        int   c;
        if (!enable) begin
            m_pc = 0; m_pos = 0;
            if (load) grab(1'b1);
            e.out  = polarity;
            e.tick = 1'b0;
        end else begin
            c = cnt_at(m_pos);
            for (int i = 0; i < C; i++) e.out[i] = (c < a_duty[i]) ^ polarity[i];
            tk  = (m_pc == int'(prescale));
            bnd = tk && (m_pos == len_of() - 1);
            e.tick = bnd;
            if (bnd) begin
                a_per = s_per; a_mode = s_mode;
                for (int i = 0; i < C; i++) a_duty[i] = s_duty[i];
            end
            if (load) grab(bnd);
            if (bnd) m_pos = 0;
            else if (tk) m_pos++;
            m_pc = tk ? 0 : m_pc + 1;
        end
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            n_tests++;
            if (pwm_out !== mon_e.out || period_tick !== mon_e.tick) begin
                n_fail++;
                $display("FAIL step t=%0t: pwm_out=%b period_tick=%b, expected pwm_out=%b period_tick=%b",
                         $time, pwm_out, period_tick, mon_e.out, mon_e.tick);
            end
        end
    end

    task automatic check_idle(input string name);
        n_tests++;
        if (pwm_out !== '0 || period_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: pwm_out=%b period_tick=%b, expected 0000 0", name, pwm_out, period_tick);
        end
    endtask

    task automatic cfg(input int ps, input int p, input logic md,
                       input logic [C*W-1:0] d, input logic [C-1:0] pol);
        enable = 1'b0; prescale = PW'(ps); period = W'(p); mode = md;
        duty_flat = d; polarity = pol; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    function automatic logic [C*W-1:0] rand_duty(input int p);
        logic [C*W-1:0] d;
        int r;
        for (int i = 0; i < C; i++) begin
            r = $urandom_range(0, 9);
            d[i*W +: W] = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : W'($urandom_range(0, p + 1));
        end
        return d;
    endfunction

    task automatic run(input int n, input int ld_pct, input int dis_pct, input bit any_cfg);
        enable = 1'b1;
        repeat (n) begin
            if (!enable) enable = ($urandom_range(0, 2) == 0);
            else if ($urandom_range(0, 99) < dis_pct) enable = 1'b0;
            load = ($urandom_range(0, 99) < ld_pct);
            if (load && any_cfg) begin
                period = W'($urandom_range(0, 12));
                mode   = 1'($urandom_range(0, 1));
            end
            if (load) duty_flat = rand_duty(period);
            if (any_cfg && $urandom_range(0, 19) == 0) polarity = C'($urandom);
            step();
            load = 1'b0;
        end
    endtask

    initial begin
        reset_model();
        polarity = 4'b1010;
        @(negedge clk); @(negedge clk);
        check_idle("reset_hold");
        rst_n = 1'b1;
        step();
        step();

        // Edge mode, P=9: 3-clk, 9-clk and two always-on channels.
        cfg(0, 9, MODE_EDGE, {8'd255, 8'd10, 8'd9, 8'd3}, 4'b0000);
        run(60, 0, 0, 1'b0);

        // Centre mode, P=4.
        cfg(0, 4, MODE_CENTRE, {8'd0, 8'd4, 8'd1, 8'd2}, 4'b0000);
        run(40, 0, 0, 1'b0);

        // Shadow update mid-period: duty0 5 -> 8.
        cfg(0, 9, MODE_EDGE, {8'd1, 8'd2, 8'd3, 8'd5}, 4'b0000);
        run(14, 0, 0, 1'b0);
        duty_flat[7:0] = 8'd8; load = 1'b1;
        step();
        load = 1'b0;
        run(30, 0, 0, 1'b0);

        // Limits: duty 0 / 255, both polarities, slow prescaler.
        cfg(0, 9, MODE_EDGE, {8'd255, 8'd0, 8'd255, 8'd0}, 4'b0000);
        run(25, 0, 0, 1'b0);
        polarity = 4'b1111;
        run(25, 0, 0, 1'b0);
        cfg(3, 9, MODE_EDGE, {8'd0, 8'd255, 8'd7, 8'd3}, 4'b0110);
        run(90, 0, 0, 1'b0);

        // Disable mid-period then resume.
        cfg(0, 9, MODE_EDGE, {8'd4, 8'd6, 8'd9, 8'd3}, 4'b0100);
        run(5, 0, 0, 1'b0);
        enable = 1'b0;
        repeat (6) step();
        run(30, 0, 0, 1'b0);

        // Random configurations with loads, enable toggles and polarity changes.
        for (int k = 0; k < 8; k++) begin
            cfg($urandom_range(0, 2), $urandom_range(0, 12), 1'($urandom_range(0, 1)),
                rand_duty(12), C'($urandom));
            run(300, 10, 3, 1'b1);
        end

        // Asynchronous reset mid-run.
        cfg(0, 9, MODE_EDGE, {8'd5, 8'd5, 8'd5, 8'd5}, 4'b1111);
        run(7, 0, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_idle("reset_async");
        reset_model();
        @(negedge clk);
        check_idle("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        cfg(1, 6, MODE_CENTRE, {8'd2, 8'd7, 8'd0, 8'd4}, 4'b0001);
        run(60, 5, 0, 1'b0);

        @(posedge clk); #2;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected outputs never compared, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
